// File: rtl/rtdf_sample_unpacker_if.sv
// Word-in / sample-out bundle for rtdf_sample_unpacker.
// The master modport drives the word source and enable/flush; the slave modport is the unpacker.
interface rtdf_sample_unpacker_if #(
    parameter int WORD_W   = 16,
    parameter int SAMPLE_W = 3,
    parameter int CNT_W    = 16
);
    localparam int BUF_W = WORD_W + 2 * SAMPLE_W;
    localparam int BC_W  = $clog2(BUF_W + 1);

    logic                enable;
    logic                flush;
    logic                word_empty;
    logic [WORD_W-1:0]   word_data;
    logic                word_read;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                underrun;
    logic [BC_W-1:0]     bit_count;
    logic [CNT_W-1:0]    underrun_count;

    modport master (
        output enable, flush, word_empty, word_data,
        input  word_read, sample_data, sample_valid, underrun, bit_count, underrun_count
    );

    modport slave (
        input  enable, flush, word_empty, word_data,
        output word_read, sample_data, sample_valid, underrun, bit_count, underrun_count
    );
endinterface

// File: rtl/rtdf_sample_unpacker.sv
// Unpacks WORD_W-bit FWFT words into an LSB-first stream of SAMPLE_W-bit samples.
// Define RTDF_UNPACK_STATS_EN to build the saturating underrun counter.
module rtdf_sample_unpacker #(
    parameter int WORD_W   = 16,
    parameter int SAMPLE_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    rtdf_sample_unpacker_if.slave bus
);
    localparam int BUF_W = WORD_W + 2 * SAMPLE_W;
    localparam int BC_W  = $clog2(BUF_W + 1);

    localparam logic [BC_W-1:0] SAMPLE_C    = BC_W'(SAMPLE_W);
    localparam logic [BC_W-1:0] WORD_C      = BC_W'(WORD_W);
    localparam logic [BC_W-1:0] LOAD_LIMIT  = BC_W'(BUF_W - WORD_W);

    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [BC_W-1:0]     cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
    logic                sample_valid_q, sample_valid_d;
    logic                underrun_q, underrun_d;

    logic                consume;
    logic                word_read;
    logic [BC_W-1:0]     next_cnt;
    logic [BUF_W-1:0]    shifted;
    logic [BUF_W-1:0]    word_ext;

    // The load lands at the post-shift fill level, so a same-edge consume and load never overlap.
    always_comb begin
        consume   = bus.enable && (cnt_q >= SAMPLE_C);
        next_cnt  = consume ? (cnt_q - SAMPLE_C) : cnt_q;
        word_read = !reset_i && !bus.flush && !bus.word_empty && (next_cnt <= LOAD_LIMIT);
        shifted   = consume ? (buf_q >> SAMPLE_W) : buf_q;
        word_ext  = {{(BUF_W - WORD_W){1'b0}}, bus.word_data};

        buf_d          = shifted;
        cnt_d          = next_cnt;
        sample_data_d  = sample_data_q;
        sample_valid_d = consume;
        underrun_d     = bus.enable && !consume;

        if (word_read) begin
            buf_d = shifted | (word_ext << next_cnt);
            cnt_d = next_cnt + WORD_C;
        end
        if (consume) begin
            sample_data_d = buf_q[SAMPLE_W-1:0];
        end
        if (bus.flush) begin
            buf_d          = '0;
            cnt_d          = '0;
            sample_data_d  = sample_data_q;
            sample_valid_d = 1'b0;
            underrun_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q          <= '0;
            cnt_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
        end
    end

`ifdef RTDF_UNPACK_STATS_EN
    logic [CNT_W-1:0] ucnt_q;

    // Counts on the same edge that raises underrun, so the count tracks the visible pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ucnt_q <= '0;
        end else if (underrun_d && (ucnt_q != {CNT_W{1'b1}})) begin
            ucnt_q <= ucnt_q + CNT_W'(1);
        end
    end

    assign bus.underrun_count = ucnt_q;
`else
    assign bus.underrun_count = {CNT_W{1'b0}};
`endif

    assign bus.word_read    = word_read;
    assign bus.sample_data  = sample_data_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.underrun     = underrun_q;
    assign bus.bit_count    = cnt_q;
endmodule
